branch_predict_resolve_unit: RTL and testbench
==============================================

Name: branch_predict_resolve_unit

Overview:
Parametrised successor to the execute-stage branch/jump resolver. Adds a direct-mapped branch target buffer (BTB) with saturating 2-bit counters for fetch-stage prediction. Also adds registered resolution with mispredict detection, redirect generation, link-address output and performance counters. Fetch queries it combinationally; execute presents one resolved control-flow instruction per cycle.

Parameters:
ADDR_W, 32, width of PCs, targets and operands
BTB_ENTRIES, 16, BTB depth; power of two, >=2; IDX_W = log2(BTB_ENTRIES)
CNT_W, 2, saturating counter width; prediction = counter MSB
PERF_W, 32, width of performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
if_pc  in  ADDR_W  fetch PC to look up
if_pred_taken  out  1  BTB hit and counter MSB=1 (combinational)
if_pred_target  out  ADDR_W  stored target on hit, else if_pc+8
ex_valid  in  1  resolve request this cycle
ex_flush  in  1  kill the request presented this cycle
ex_pc  in  ADDR_W  PC of the control-flow instruction
ex_branch, ex_cmp_zero, ex_eq, ex_neq, ex_gtz, ex_ltz, ex_jmp, ex_jr, ex_link  in  1 each  decoded control
ex_rs, ex_rt  in  ADDR_W  operands
ex_jump_addr, ex_branch_addr  in  ADDR_W  precomputed targets
ex_pred_taken  in  1  prediction carried with the instruction
ex_pred_target  in  ADDR_W  predicted target carried with it
redirect_valid  out  1  registered one-cycle pulse on mispredict
redirect_pc  out  ADDR_W  registered correct next PC
link_valid  out  1  registered; resolved instruction had ex_link
link_addr  out  ADDR_W  registered ex_pc+8
perf_branches  out  PERF_W  count of accepted resolves
perf_mispredicts  out  PERF_W  count of redirects issued

Behaviour:
- Reset: every BTB valid bit=0; counters=01 (weakly not-taken); redirect_valid=0, link_valid=0; redirect_pc=0, link_addr=0; perf counters=0. Reset wins over a simultaneous ex_valid.
- Accept = ex_valid & !ex_flush & !rst. No accept: no BTB write, no counter change, redirect_valid/link_valid=0 next cycle.
- Index = pc[IDX_W+1:2]. Tag = pc[ADDR_W-1:IDX_W+2]. Hit = valid & tag match.
- Conditions, operands unsigned-bit/signed-sign:
  - eq = cmp_zero ? rs==0 : rs==rt
  - neq = cmp_zero ? rs!=0 : rs!=rt
  - gtz = rs!=0 & !rs[ADDR_W-1]
  - ltz = rs[ADDR_W-1]
- taken = ex_branch & ((ex_eq&eq)|(ex_neq&neq)|(ex_cmp_zero&ex_gtz&gtz)|(ex_cmp_zero&ex_ltz&ltz)).
- act_taken = taken|ex_jmp|ex_jr.
- act_target = ex_jmp ? jump_addr : ex_jr ? rs : branch_addr. Priority is jmp > jr > branch.
- next_pc = act_taken ? act_target : ex_pc+8 (delay slot). Adders wrap modulo 2^ADDR_W.
- mispredict = act_taken != ex_pred_taken, or act_taken & (act_target != ex_pred_target).
- Latency: on accept, all registered outputs update at the next edge. redirect_valid=mispredict, redirect_pc=next_pc, link_valid=ex_link, link_addr=ex_pc+8. All outputs hold 1 cycle and are then rewritten by the next accept/no-accept.
- perf_branches += 1 per accept. perf_mispredicts += 1 per mispredict. Both wrap at 2^PERF_W.
- BTB update on accept (ex_jr never allocates or updates):
  - ex_branch, hit: counter +1 if taken (saturate at all-ones), else -1 (saturate at 0). Target rewritten with branch_addr.
  - ex_branch, miss, taken: allocate/overwrite entry. Tag set, target=branch_addr, counter=10.
  - ex_branch, miss, not taken: no write.
  - ex_jmp: allocate/overwrite, target=jump_addr, counter=all-ones.
- Lookup reads state before the edge. A same-cycle update to the looked-up index is visible only from the next cycle (no bypass).
- Instruction with none of branch/jmp/jr but ex_valid: act_taken=0; counts as a branch; mispredicts only if ex_pred_taken=1. This is the aliasing recovery path.

Test Plan:
1. Reset, then if_pc=0x400 -> if_pred_taken=0, if_pred_target=0x408; perf counters 0.
2. beq at 0x400, rs=rt=5, branch_addr=0x500, pred 0 -> next cycle redirect_valid=1, redirect_pc=0x500, perf_mispredicts=1. Lookup 0x400 then gives pred_taken=1, target 0x500.
3. Same beq resolved not-taken twice (rs=1, rt=2) -> counter 10→01→00. Lookup pred_taken=0. Third not-taken, pred 0 -> redirect_valid=0. Counter stays 00 (saturation).
4. jal at 0x1000, jump_addr=0x2000, pred 0 -> redirect_pc=0x2000, link_valid=1, link_addr=0x1008. BTB counter=11.
5. jr, rs=0x3004, pred taken target 0x3000 -> redirect_pc=0x3004, no BTB change. Then bltz with rs=0x80000000 taken, and bgtz with rs=0 not taken.
6. ex_valid with ex_flush=1 on a mispredicting beq -> no redirect, perf unchanged. rst asserted mid-stream clears BTB (lookups miss next cycle) and the counters.

Source files
------------

// File: rtl/branch_predict_resolve_unit.sv
// Execute-stage branch/jump resolver with a direct-mapped BTB for fetch prediction,
// registered redirect/link outputs and performance counters.
module branch_predict_resolve_unit #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned BTB_ENTRIES = 16,
   parameter int unsigned CNT_W       = 2,
   parameter int unsigned PERF_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] if_pc,
   output logic              if_pred_taken,
   output logic [ADDR_W-1:0] if_pred_target,
   input  logic              ex_valid,
   input  logic              ex_flush,
   input  logic [ADDR_W-1:0] ex_pc,
   input  logic              ex_branch,
   input  logic              ex_cmp_zero,
   input  logic              ex_eq,
   input  logic              ex_neq,
   input  logic              ex_gtz,
   input  logic              ex_ltz,
   input  logic              ex_jmp,
   input  logic              ex_jr,
   input  logic              ex_link,
   input  logic [ADDR_W-1:0] ex_rs,
   input  logic [ADDR_W-1:0] ex_rt,
   input  logic [ADDR_W-1:0] ex_jump_addr,
   input  logic [ADDR_W-1:0] ex_branch_addr,
   input  logic              ex_pred_taken,
   input  logic [ADDR_W-1:0] ex_pred_target,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              link_valid,
   output logic [ADDR_W-1:0] link_addr,
   output logic [PERF_W-1:0] perf_branches,
   output logic [PERF_W-1:0] perf_mispredicts
);

   localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
   localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_WEAK_T = {1'b1, {(CNT_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_WEAK_N = {1'b0, {(CNT_W-1){1'b1}}};

   logic              btb_valid_q [BTB_ENTRIES];
   logic [TAG_W-1:0]  btb_tag_q   [BTB_ENTRIES];
   logic [ADDR_W-1:0] btb_tgt_q   [BTB_ENTRIES];
   logic [CNT_W-1:0]  btb_cnt_q   [BTB_ENTRIES];

   // Fetch-side lookup
   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             if_hit;

   assign if_idx         = if_pc[IDX_W+1:2];
   assign if_tag         = if_pc[ADDR_W-1:IDX_W+2];
   assign if_hit         = btb_valid_q[if_idx] && (btb_tag_q[if_idx] == if_tag);
   assign if_pred_taken  = if_hit && btb_cnt_q[if_idx][CNT_W-1];
   assign if_pred_target = if_hit ? btb_tgt_q[if_idx] : if_pc + ADDR_W'(8);

   // Execute-side resolution
   logic [IDX_W-1:0]  ex_idx;
   logic [TAG_W-1:0]  ex_tag;
   logic              ex_hit;
   logic              accept;
   logic              rs_zero, c_eq, c_neq, c_gtz, c_ltz;
   logic              taken, act_taken, mispredict;
   logic [ADDR_W-1:0] act_target, seq_pc, next_pc;

   assign ex_idx  = ex_pc[IDX_W+1:2];
   assign ex_tag  = ex_pc[ADDR_W-1:IDX_W+2];
   assign ex_hit  = btb_valid_q[ex_idx] && (btb_tag_q[ex_idx] == ex_tag);
   assign accept  = ex_valid && !ex_flush && !rst;

   assign rs_zero = (ex_rs == '0);
   assign c_eq    = ex_cmp_zero ? rs_zero : (ex_rs == ex_rt);
   assign c_neq   = !c_eq;
   assign c_gtz   = !rs_zero && !ex_rs[ADDR_W-1];
   assign c_ltz   = ex_rs[ADDR_W-1];

   assign taken = ex_branch && ((ex_eq && c_eq) || (ex_neq && c_neq) ||
                                (ex_cmp_zero && ex_gtz && c_gtz) ||
                                (ex_cmp_zero && ex_ltz && c_ltz));
   assign act_taken  = taken || ex_jmp || ex_jr;
   assign act_target = ex_jmp ? ex_jump_addr : (ex_jr ? ex_rs : ex_branch_addr);
   assign seq_pc     = ex_pc + ADDR_W'(8);
   assign next_pc    = act_taken ? act_target : seq_pc;
   assign mispredict = (act_taken != ex_pred_taken) ||
                       (act_taken && (act_target != ex_pred_target));

   // BTB write decision; register-indirect jumps never touch the BTB
   logic              upd_en;
   logic [CNT_W-1:0]  upd_cnt;
   logic [ADDR_W-1:0] upd_tgt;

   always_comb begin
      upd_en  = 1'b0;
      upd_cnt = btb_cnt_q[ex_idx];
      upd_tgt = ex_branch_addr;
      if (accept && !ex_jr) begin
         if (ex_jmp) begin
            upd_en  = 1'b1;
            upd_cnt = CNT_MAX;
            upd_tgt = ex_jump_addr;
         end else if (ex_branch) begin
            if (ex_hit) begin
               upd_en = 1'b1;
               if (taken) begin
                  if (btb_cnt_q[ex_idx] != CNT_MAX) upd_cnt = btb_cnt_q[ex_idx] + CNT_W'(1);
               end else begin
                  if (btb_cnt_q[ex_idx] != '0) upd_cnt = btb_cnt_q[ex_idx] - CNT_W'(1);
               end
            end else if (taken) begin
               upd_en  = 1'b1;
               upd_cnt = CNT_WEAK_T;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid_q[i] <= 1'b0;
            btb_tag_q[i]   <= '0;
            btb_tgt_q[i]   <= '0;
            btb_cnt_q[i]   <= CNT_WEAK_N;
         end
      end else if (upd_en) begin
         btb_valid_q[ex_idx] <= 1'b1;
         btb_tag_q[ex_idx]   <= ex_tag;
         btb_tgt_q[ex_idx]   <= upd_tgt;
         btb_cnt_q[ex_idx]   <= upd_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_valid   <= 1'b0;
         redirect_pc      <= '0;
         link_valid       <= 1'b0;
         link_addr        <= '0;
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else begin
         redirect_valid <= accept && mispredict;
         link_valid     <= accept && ex_link;
         if (accept) begin
            redirect_pc   <= next_pc;
            link_addr     <= seq_pc;
            perf_branches <= perf_branches + PERF_W'(1);
            if (mispredict) perf_mispredicts <= perf_mispredicts + PERF_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// Randomized self-checking bench for branch_predict_resolve_unit against a
// behavioural BTB/resolution model.
module tb_branch_predict_resolve_unit;

   localparam int unsigned NENT = 16;
   localparam int unsigned IDXW = 4;
   localparam int          CMAX = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic [31:0] if_pred_target;
   logic        ex_valid, ex_flush;
   logic [31:0] ex_pc;
   logic        ex_branch, ex_cmp_zero, ex_eq, ex_neq, ex_gtz, ex_ltz, ex_jmp, ex_jr, ex_link;
   logic [31:0] ex_rs, ex_rt, ex_jump_addr, ex_branch_addr;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        link_valid;
   logic [31:0] link_addr;
   logic [31:0] perf_branches, perf_mispredicts;

   branch_predict_resolve_unit dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
      .if_pred_target(if_pred_target), .ex_valid(ex_valid), .ex_flush(ex_flush),
      .ex_pc(ex_pc), .ex_branch(ex_branch), .ex_cmp_zero(ex_cmp_zero), .ex_eq(ex_eq),
      .ex_neq(ex_neq), .ex_gtz(ex_gtz), .ex_ltz(ex_ltz), .ex_jmp(ex_jmp), .ex_jr(ex_jr),
      .ex_link(ex_link), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_jump_addr(ex_jump_addr),
      .ex_branch_addr(ex_branch_addr), .ex_pred_taken(ex_pred_taken),
      .ex_pred_target(ex_pred_target), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .link_valid(link_valid), .link_addr(link_addr),
      .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Behavioural model state
   bit          m_valid [NENT];
   int unsigned m_tag   [NENT];
   bit [31:0]   m_tgt   [NENT];
   int          m_cnt   [NENT];
   bit [31:0]   m_pb, m_pm;
   bit          e_rv, e_lv;
   bit [31:0]   e_rpc, e_laddr;

   function automatic int unsigned idx_of(input bit [31:0] pc);
      return (pc / 4) % NENT;
   endfunction

   function automatic int unsigned tag_of(input bit [31:0] pc);
      return pc >> (IDXW + 2);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NENT; i++) begin
         m_valid[i] = 0;
         m_cnt[i]   = 1;
      end
      m_pb = 0; m_pm = 0;
      e_rv = 0; e_lv = 0; e_rpc = 0; e_laddr = 0;
   endtask

   task automatic model_lookup(input bit [31:0] pc, output bit pt, output bit [31:0] tgt);
      bit hit;
      hit = m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
      pt  = hit && (m_cnt[idx_of(pc)] >= 2);
      tgt = hit ? m_tgt[idx_of(pc)] : pc + 32'd8;
   endtask

   task automatic model_step(output bit addr_known);
      bit tk, at, misp, hit;
      bit [31:0] atgt, npc;
      int unsigned ix;
      addr_known = 0;
      if (rst) begin
         model_reset();
         addr_known = 1;
         return;
      end
      if (!(ex_valid && !ex_flush)) begin
         e_rv = 0; e_lv = 0;
         return;
      end
      tk = 0;
      if (ex_branch) begin
         if (ex_eq  && (ex_cmp_zero ? ex_rs == 0 : ex_rs == ex_rt)) tk = 1;
         if (ex_neq && (ex_cmp_zero ? ex_rs != 0 : ex_rs != ex_rt)) tk = 1;
         if (ex_cmp_zero && ex_gtz && $signed(ex_rs) > 0) tk = 1;
         if (ex_cmp_zero && ex_ltz && $signed(ex_rs) < 0) tk = 1;
      end
      at = tk || ex_jmp || ex_jr;
      if (ex_jmp) atgt = ex_jump_addr;
      else if (ex_jr) atgt = ex_rs;
      else atgt = ex_branch_addr;
      npc  = at ? atgt : ex_pc + 32'd8;
      misp = (at != ex_pred_taken) || (at && atgt != ex_pred_target);
      m_pb++;
      if (misp) m_pm++;
      e_rv = misp; e_rpc = npc; e_lv = ex_link; e_laddr = ex_pc + 32'd8;
      addr_known = 1;
      ix  = idx_of(ex_pc);
      hit = m_valid[ix] && m_tag[ix] == tag_of(ex_pc);
      if (ex_jr) return;
      if (ex_jmp) begin
         m_valid[ix] = 1; m_tag[ix] = tag_of(ex_pc); m_tgt[ix] = ex_jump_addr; m_cnt[ix] = CMAX;
      end else if (ex_branch) begin
         if (hit) begin
            m_cnt[ix] = tk ? ((m_cnt[ix] + 1 > CMAX) ? CMAX : m_cnt[ix] + 1)
                           : ((m_cnt[ix] - 1 < 0) ? 0 : m_cnt[ix] - 1);
            m_tgt[ix] = ex_branch_addr;
         end else if (tk) begin
            m_valid[ix] = 1; m_tag[ix] = tag_of(ex_pc); m_tgt[ix] = ex_branch_addr; m_cnt[ix] = 2;
         end
      end
   endtask

   // One clock: check fetch lookup before the edge, registered outputs after it
   task automatic cycle();
      bit pt, ak;
      bit [31:0] ptgt;
      #1;
      model_lookup(if_pc, pt, ptgt);
      check("lookup_taken", {63'd0, if_pred_taken}, {63'd0, pt});
      check("lookup_target", {32'd0, if_pred_target}, {32'd0, ptgt});
      model_step(ak);
      @(posedge clk);
      #1;
      check("redirect_valid", {63'd0, redirect_valid}, {63'd0, e_rv});
      check("link_valid", {63'd0, link_valid}, {63'd0, e_lv});
      check("perf_branches", {32'd0, perf_branches}, {32'd0, m_pb});
      check("perf_mispredicts", {32'd0, perf_mispredicts}, {32'd0, m_pm});
      if (ak) begin
         check("redirect_pc", {32'd0, redirect_pc}, {32'd0, e_rpc});
         check("link_addr", {32'd0, link_addr}, {32'd0, e_laddr});
      end
   endtask

   task automatic clear_ex();
      ex_valid = 0; ex_flush = 0; ex_pc = 0; ex_branch = 0; ex_cmp_zero = 0; ex_eq = 0;
      ex_neq = 0; ex_gtz = 0; ex_ltz = 0; ex_jmp = 0; ex_jr = 0; ex_link = 0; ex_rs = 0;
      ex_rt = 0; ex_jump_addr = 0; ex_branch_addr = 0; ex_pred_taken = 0; ex_pred_target = 0;
   endtask

   task automatic beq(input bit [31:0] pc, input bit [31:0] rs, input bit [31:0] rt,
                      input bit [31:0] ba, input bit pt, input bit [31:0] ptg);
      clear_ex();
      ex_valid = 1; ex_branch = 1; ex_eq = 1; ex_pc = pc; ex_rs = rs; ex_rt = rt;
      ex_branch_addr = ba; ex_pred_taken = pt; ex_pred_target = ptg;
   endtask

   bit [31:0] pc_pool  [8] = '{32'h400, 32'h440, 32'h404, 32'h1000, 32'h1004, 32'h2008,
                               32'hFFFF_FFFC, 32'h3000_0040};
   bit [31:0] val_pool [6] = '{32'h0, 32'h5, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h3004};

   initial begin
      bit pt;
      bit [31:0] ptg;
      int kind;
      clear_ex();
      if_pc = 32'h400;
      rst = 1;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      cycle();
      rst = 0;

      // Reset state and first lookup
      cycle();
      check("reset_pred_target", {32'd0, if_pred_target}, 64'h408);

      // Taken beq allocates, mispredicts
      beq(32'h400, 5, 5, 32'h500, 0, 0);
      cycle();
      check("beq_redirect_pc", {32'd0, redirect_pc}, 64'h500);
      clear_ex();
      cycle();
      check("beq_alloc_pred", {63'd0, if_pred_taken}, 64'h1);

      // Not-taken thrice: counter walks down and saturates
      beq(32'h400, 1, 2, 32'h500, 1, 32'h500);
      cycle();
      beq(32'h400, 1, 2, 32'h500, 0, 0);
      cycle();
      beq(32'h400, 1, 2, 32'h500, 0, 0);
      cycle();
      check("beq_sat_noredirect", {63'd0, redirect_valid}, 64'h0);

      // jal
      clear_ex();
      ex_valid = 1; ex_jmp = 1; ex_link = 1; ex_pc = 32'h1000; ex_jump_addr = 32'h2000;
      if_pc = 32'h1000;
      cycle();
      check("jal_link_addr", {32'd0, link_addr}, 64'h1008);

      // jr, bltz, bgtz
      clear_ex();
      ex_valid = 1; ex_jr = 1; ex_pc = 32'h1004; ex_rs = 32'h3004;
      ex_pred_taken = 1; ex_pred_target = 32'h3000;
      cycle();
      clear_ex();
      ex_valid = 1; ex_branch = 1; ex_cmp_zero = 1; ex_ltz = 1; ex_pc = 32'h404;
      ex_rs = 32'h8000_0000; ex_branch_addr = 32'h600;
      cycle();
      clear_ex();
      ex_valid = 1; ex_branch = 1; ex_cmp_zero = 1; ex_gtz = 1; ex_pc = 32'h408;
      ex_rs = 0; ex_branch_addr = 32'h700;
      cycle();

      // Flushed request, then reset mid-stream with a live request
      beq(32'h440, 7, 7, 32'h900, 0, 0);
      ex_flush = 1;
      cycle();
      beq(32'h440, 7, 7, 32'h900, 0, 0);
      rst = 1;
      cycle();
      rst = 0;
      clear_ex();
      if_pc = 32'h1000;
      cycle();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         clear_ex();
         rst      = ($urandom_range(0, 199) == 0);
         ex_valid = ($urandom_range(0, 99) < 85);
         ex_flush = ($urandom_range(0, 99) < 12);
         ex_pc    = pc_pool[$urandom_range(0, 7)];
         if_pc    = ($urandom_range(0, 3) == 0) ? $urandom() : pc_pool[$urandom_range(0, 7)];
         ex_rs    = ($urandom_range(0, 2) == 0) ? $urandom() : val_pool[$urandom_range(0, 5)];
         ex_rt    = ($urandom_range(0, 2) == 0) ? $urandom() : val_pool[$urandom_range(0, 5)];
         ex_jump_addr   = $urandom() & 32'hFFFF_FFFC;
         ex_branch_addr = pc_pool[$urandom_range(0, 7)];
         ex_link  = $urandom_range(0, 1);
         kind     = $urandom_range(0, 5);
         case (kind)
            0, 1, 2: begin
               ex_branch   = 1;
               ex_cmp_zero = $urandom_range(0, 1);
               ex_eq       = $urandom_range(0, 1);
               ex_neq      = !ex_eq && $urandom_range(0, 1);
               ex_gtz      = $urandom_range(0, 1);
               ex_ltz      = $urandom_range(0, 1);
            end
            3: ex_jmp = 1;
            4: ex_jr  = 1;
            default: ;
         endcase
         if ($urandom_range(0, 1) == 1) begin
            model_lookup(ex_pc, pt, ptg);
            ex_pred_taken = pt; ex_pred_target = ptg;
         end else begin
            ex_pred_taken  = $urandom_range(0, 1);
            ex_pred_target = ($urandom_range(0, 1) == 1) ? ex_branch_addr : ex_rs;
         end
         cycle();
      end
      rst = 0;
      clear_ex();
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
